// File: rtl/oam_dma.sv
// Sprite-memory DMA engine: snoops a CPU write to REG_ADDR, halts the CPU and
// copies the 256-byte page {page,8'h00..8'hFF} to DEST_ADDR, one byte per READ/WRITE pair.
module oam_dma #(
    parameter logic [15:0] REG_ADDR  = 16'h4014,
    parameter logic [15:0] DEST_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_rw,
    input  logic        cpu_halted,
    input  logic [7:0]  bus_rdata,
    output logic        rdy,
    output logic        dma_en,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_wdata
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_q;
    logic       parity;
    logic       trigger;

    // Snooping only happens in IDLE, so the block's own bus cycles can never re-trigger it.
    assign trigger = (state == IDLE) && !cpu_rw && (cpu_addr == REG_ADDR);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state  <= IDLE;
            page   <= '0;
            idx    <= '0;
            data_q <= '0;
            parity <= 1'b0;
        end else begin
            state  <= state_nxt;
            parity <= ~parity;
            if (trigger) begin
                page <= cpu_data;
            end
            if (state == READ) begin
                data_q <= bus_rdata;
            end
            // 8-bit increment wraps FF -> 00 on the final WRITE.
            if (state == WRITE) begin
                idx <= idx + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        dma_en    = 1'b0;
        dma_rw    = 1'b1;
        dma_addr  = '0;
        dma_wdata = '0;
        unique case (state)
            IDLE: begin
                rdy = 1'b1;
                if (trigger) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                if (cpu_halted) begin
                    state_nxt = parity ? READ : ALIGN;
                end
            end
            ALIGN: begin
                dma_en    = 1'b1;
                dma_addr  = {page, idx};
                state_nxt = READ;
            end
            READ: begin
                dma_en    = 1'b1;
                dma_addr  = {page, idx};
                state_nxt = WRITE;
            end
            WRITE: begin
                dma_en    = 1'b1;
                dma_rw    = 1'b0;
                dma_addr  = DEST_ADDR;
                dma_wdata = data_q;
                state_nxt = (idx == 8'hFF) ? IDLE : READ;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
